// File: rtl/lcd_timing_monitor_pkg.sv
`default_nettype none
// ============================================================================
// lcd_timing_monitor_pkg - panel timing defaults, err_flags bit map, FSM type
// Revision: 1.0
// ============================================================================
package lcd_timing_monitor_pkg;

   // Default 480x272 panel timing, shared with the LCD timing generator
   localparam int DEF_H_ACTIVE = 480;
   localparam int DEF_V_ACTIVE = 272;
   localparam int DEF_H_TOTAL  = 525;

   localparam int ERR_H_ACTIVE   = 0;
   localparam int ERR_V_ACTIVE   = 1;
   localparam int ERR_H_TOTAL    = 2;
   localparam int ERR_DE_IN_SYNC = 3;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_MEASURE = 1'b1
   } mon_state_t;

endpackage
`default_nettype wire

// File: rtl/lcd_sync_edge.sv
`default_nettype none
// ============================================================================
// lcd_sync_edge - pix_ce-gated sync normaliser (1 = active) and leading-edge strobe
// Revision: 1.0
// ============================================================================
module lcd_sync_edge #(
   parameter bit POL = 1'b0
) (
   input  logic ref_clk,
   input  logic rst,
   input  logic pix_ce,
   input  logic sync_in,
   output logic active,
   output logic lead
);

   logic r_prev;

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         active <= 1'b0;
         r_prev <= 1'b0;
      end else if (pix_ce) begin
         active <= (sync_in == POL);
         r_prev <= active;
      end
   end

   assign lead = active & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/lcd_timing_monitor.sv
`default_nettype none
// ============================================================================
// lcd_timing_monitor - measures RGB LCD frame geometry, flags violations, reports lock
// Revision: 1.0
// ============================================================================
module lcd_timing_monitor
   import lcd_timing_monitor_pkg::*;
#(
   parameter int H_ACTIVE    = DEF_H_ACTIVE,
   parameter int V_ACTIVE    = DEF_V_ACTIVE,
   parameter int H_TOTAL     = DEF_H_TOTAL,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int CW          = 12,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          ref_clk,
   input  logic          rst,
   input  logic          pix_ce,
   input  logic          lcd_de,
   input  logic          lcd_hsync,
   input  logic          lcd_vsync,
   input  logic [23:0]   lcd_rgb,
   output logic          frame_done,
   output logic [CW-1:0] meas_h_active,
   output logic [CW-1:0] meas_v_active,
   output logic [CW-1:0] meas_h_total,
   output logic [31:0]   frame_sum,
   output logic [3:0]    err_flags,
   output logic          locked
);

   localparam logic [CW-1:0] C_CNT_MAX  = '1;
   localparam logic [CW-1:0] C_H_ACTIVE = CW'(H_ACTIVE);
   localparam logic [CW-1:0] C_V_ACTIVE = CW'(V_ACTIVE);
   localparam logic [CW-1:0] C_H_TOTAL  = CW'(H_TOTAL);
   localparam int            C_LCK_W    = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
   localparam logic [C_LCK_W-1:0] C_LOCK = C_LCK_W'(LOCK_FRAMES);

   logic w_hs_active, w_hs_lead, w_vs_active, w_vs_lead;
   logic r_de;
   logic [23:0] r_rgb;

   mon_state_t r_state, w_state_nxt;
   logic w_frame_close, w_sample_en;

   logic [CW-1:0] r_line_de, r_h_cnt, r_v_cnt, r_last_h_active, r_last_period;
   logic [31:0]   r_sum;
   logic [3:0]    r_err;
   logic          r_have_hs;
   logic [C_LCK_W-1:0] r_good_cnt;

   logic          w_line_close;
   logic [CW-1:0] w_c_v, w_c_hact, w_c_period;
   logic [3:0]    w_c_err, w_frame_err;
   logic [CW-1:0] w_n_line_de, w_n_h_cnt, w_n_v, w_n_hact, w_n_period;
   logic [31:0]   w_n_sum;
   logic [3:0]    w_n_err;
   logic          w_n_have_hs;
   logic [C_LCK_W-1:0] w_good_nxt;

   lcd_sync_edge #(.POL(HS_POL)) u_hs_edge (
      .ref_clk(ref_clk), .rst(rst), .pix_ce(pix_ce),
      .sync_in(lcd_hsync), .active(w_hs_active), .lead(w_hs_lead)
   );

   lcd_sync_edge #(.POL(VS_POL)) u_vs_edge (
      .ref_clk(ref_clk), .rst(rst), .pix_ce(pix_ce),
      .sync_in(lcd_vsync), .active(w_vs_active), .lead(w_vs_lead)
   );

   always_ff @(posedge ref_clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == ST_IDLE && pix_ce && w_vs_lead) w_state_nxt = ST_MEASURE;
   end

   always_comb begin
      w_frame_close = pix_ce & w_vs_lead & (r_state == ST_MEASURE);
      w_sample_en   = pix_ce & ((r_state == ST_MEASURE) | w_vs_lead);
   end

   always_comb begin
      // Close the open line first (hsync or vsync edge), then the frame
      w_line_close = w_hs_lead | w_vs_lead;
      w_c_v        = r_v_cnt;
      w_c_hact     = r_last_h_active;
      w_c_period   = r_last_period;
      w_c_err      = r_err;
      if (w_line_close && r_line_de != '0) begin
         if (r_v_cnt != C_CNT_MAX) w_c_v = r_v_cnt + 1'b1;
         w_c_hact = r_line_de;
         if (r_line_de != C_H_ACTIVE) w_c_err[ERR_H_ACTIVE] = 1'b1;
      end
      if (w_hs_lead && r_have_hs) begin
         w_c_period = r_h_cnt;
         if (r_h_cnt != C_H_TOTAL) w_c_err[ERR_H_TOTAL] = 1'b1;
      end
      w_frame_err               = w_c_err;
      w_frame_err[ERR_V_ACTIVE] = (w_c_v != C_V_ACTIVE);

      // The edge sample itself belongs to the new line / new frame
      w_n_v       = w_vs_lead ? '0 : w_c_v;
      w_n_hact    = w_vs_lead ? '0 : w_c_hact;
      w_n_period  = w_vs_lead ? '0 : w_c_period;
      w_n_err     = w_vs_lead ? '0 : w_c_err;
      w_n_have_hs = w_hs_lead | (r_have_hs & ~w_vs_lead);
      w_n_sum     = (w_vs_lead ? 32'd0 : r_sum) + (r_de ? {8'd0, r_rgb} : 32'd0);
      w_n_line_de = w_line_close ? '0 : r_line_de;
      if (r_de) begin
         if (w_n_line_de == C_CNT_MAX) w_n_err[ERR_H_ACTIVE] = 1'b1;
         else                          w_n_line_de = w_n_line_de + 1'b1;
      end
      if (w_hs_lead) begin
         w_n_h_cnt = CW'(1);
      end else if (r_h_cnt == C_CNT_MAX) begin
         w_n_h_cnt = r_h_cnt;
         w_n_err[ERR_H_TOTAL] = 1'b1;
      end else begin
         w_n_h_cnt = r_h_cnt + 1'b1;
      end
      if (r_de && (w_hs_active || w_vs_active)) w_n_err[ERR_DE_IN_SYNC] = 1'b1;

      if (w_frame_err != 4'd0)      w_good_nxt = '0;
      else if (r_good_cnt >= C_LOCK) w_good_nxt = r_good_cnt;
      else                          w_good_nxt = r_good_cnt + 1'b1;
   end

   always_ff @(posedge ref_clk) begin
      if (rst) begin
         r_de            <= 1'b0;
         r_rgb           <= '0;
         r_line_de       <= '0;
         r_h_cnt         <= '0;
         r_v_cnt         <= '0;
         r_last_h_active <= '0;
         r_last_period   <= '0;
         r_sum           <= '0;
         r_err           <= '0;
         r_have_hs       <= 1'b0;
         r_good_cnt      <= '0;
         frame_done      <= 1'b0;
         meas_h_active   <= '0;
         meas_v_active   <= '0;
         meas_h_total    <= '0;
         frame_sum       <= '0;
         err_flags       <= '0;
         locked          <= 1'b0;
      end else begin
         frame_done <= w_frame_close;
         if (pix_ce) begin
            r_de  <= lcd_de;
            r_rgb <= lcd_rgb;
         end
         if (w_sample_en) begin
            r_line_de       <= w_n_line_de;
            r_h_cnt         <= w_n_h_cnt;
            r_v_cnt         <= w_n_v;
            r_last_h_active <= w_n_hact;
            r_last_period   <= w_n_period;
            r_sum           <= w_n_sum;
            r_err           <= w_n_err;
            r_have_hs       <= w_n_have_hs;
         end
         if (w_frame_close) begin
            meas_h_active <= w_c_hact;
            meas_v_active <= w_c_v;
            meas_h_total  <= w_c_period;
            frame_sum     <= r_sum;
            err_flags     <= w_frame_err;
            r_good_cnt    <= w_good_nxt;
            locked        <= (w_good_nxt >= C_LOCK);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_monitor.sv
`default_nettype none
// ============================================================================
// tb_lcd_timing_monitor - randomized frames checked against a frame-level model
// Revision: 1.0
// ============================================================================
module tb_lcd_timing_monitor;

   localparam int H_ACTIVE = 16;
   localparam int V_ACTIVE = 6;
   localparam int H_TOTAL  = 24;
   localparam int CW       = 12;
   localparam int LOCK     = 2;
   localparam bit HS_POL   = 1'b0;
   localparam bit VS_POL   = 1'b1;
   localparam int HS_W     = 3;
   localparam int DE_START = 5;

   logic          ref_clk = 1'b0;
   logic          rst;
   logic          pix_ce;
   logic          lcd_de;
   logic          lcd_hsync;
   logic          lcd_vsync;
   logic [23:0]   lcd_rgb;
   logic          frame_done;
   logic [CW-1:0] meas_h_active, meas_v_active, meas_h_total;
   logic [31:0]   frame_sum;
   logic [3:0]    err_flags;
   logic          locked;

   lcd_timing_monitor #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .H_TOTAL(H_TOTAL),
      .HS_POL(HS_POL), .VS_POL(VS_POL), .CW(CW), .LOCK_FRAMES(LOCK)
   ) dut (
      .ref_clk(ref_clk), .rst(rst), .pix_ce(pix_ce),
      .lcd_de(lcd_de), .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_rgb(lcd_rgb),
      .frame_done(frame_done), .meas_h_active(meas_h_active), .meas_v_active(meas_v_active),
      .meas_h_total(meas_h_total), .frame_sum(frame_sum), .err_flags(err_flags), .locked(locked)
   );

   always #5 ref_clk = ~ref_clk;

   typedef struct {
      int          h;
      int          v;
      int          ht;
      logic [31:0] sum;
      logic [3:0]  err;
      logic        lck;
      longint      cyc;
   } exp_t;

   exp_t   exp_q[$];
   exp_t   pend;
   exp_t   got_e;
   bit     have_pend = 1'b0;
   bit     armed = 1'b0;
   int     good_cnt = 0;
   longint cyc = 0;
   longint drv_cyc = 0;
   int     n_checks = 0;
   int     n_fail = 0;
   logic   prev_fd = 1'b0;

   always @(posedge ref_clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_zero_outputs(input string ctx);
      check_val({ctx, "_frame_done"}, frame_done, 0);
      check_val({ctx, "_h_active"}, meas_h_active, 0);
      check_val({ctx, "_v_active"}, meas_v_active, 0);
      check_val({ctx, "_h_total"}, meas_h_total, 0);
      check_val({ctx, "_sum"}, frame_sum, 0);
      check_val({ctx, "_err"}, err_flags, 0);
      check_val({ctx, "_locked"}, locked, 0);
   endtask

   // Result checker: every frame_done must match the oldest predicted frame
   always @(negedge ref_clk) begin
      if (frame_done) begin
         check_val("fd_width", prev_fd, 0);
         if (exp_q.size() == 0) begin
            check_val("spurious_frame_done", frame_done, 0);
         end else begin
            got_e = exp_q.pop_front();
            check_val("fd_latency", cyc, got_e.cyc);
            check_val("h_active", meas_h_active, got_e.h);
            check_val("v_active", meas_v_active, got_e.v);
            check_val("h_total", meas_h_total, got_e.ht);
            check_val("frame_sum", frame_sum, got_e.sum);
            check_val("err_flags", err_flags, got_e.err);
            check_val("locked", locked, got_e.lck);
         end
      end
      prev_fd = frame_done;
   end

   task automatic drive_sample(input logic de, input logic hs, input logic vs,
                               input logic [23:0] rgb, input int d);
      @(negedge ref_clk);
      drv_cyc   = cyc;
      pix_ce    = 1'b1;
      lcd_de    = de;
      lcd_hsync = hs ? HS_POL : ~HS_POL;
      lcd_vsync = vs ? VS_POL : ~VS_POL;
      lcd_rgb   = rgb;
      for (int k = 1; k < d; k++) begin
         @(negedge ref_clk);
         pix_ce    = 1'b0;
         lcd_de    = 1'($urandom);
         lcd_hsync = 1'($urandom);
         lcd_vsync = 1'($urandom);
         lcd_rgb   = 24'($urandom);
      end
   endtask

   // One frame: 2 vsync lines, 1 back-porch line, nact active lines, 1 front-porch line.
   // Fault knobs are active-line indices (-1 = none); abort_ln resets mid-line.
   task automatic drive_frame(input int nact, input int short_ln, input int long_ln,
                              input int sync_ln, input int vs_off, input int d, input int abort_ln);
      int          nlines;
      int          a, per, dec, dstart;
      logic        hs, vs, de, act;
      logic [23:0] rgb;
      logic [31:0] fsum;
      nlines = nact + 4;
      fsum   = 32'd0;
      for (int ln = 0; ln < nlines; ln++) begin
         a      = ln - 3;
         act    = (a >= 0) && (a < nact);
         per    = (act && a == long_ln) ? H_TOTAL + 1 : H_TOTAL;
         dec    = !act ? 0 : ((a == short_ln) ? H_ACTIVE - 1 : H_ACTIVE);
         dstart = (act && a == sync_ln) ? 0 : DE_START;
         for (int c = 0; c < per; c++) begin
            if (act && a == abort_ln && c == 10) begin
               @(negedge ref_clk);
               rst    = 1'b1;
               pix_ce = 1'b1;
               exp_q.delete();
               armed     = 1'b0;
               have_pend = 1'b0;
               good_cnt  = 0;
               @(negedge ref_clk);
               check_zero_outputs("midrst");
               rst = 1'b0;
               return;
            end
            hs  = (c < HS_W);
            vs  = (ln == 0 && c >= vs_off) || (ln == 1) || (ln == 2 && c < vs_off);
            de  = act && (c >= dstart) && (c < dstart + dec);
            rgb = 24'($urandom);
            if (de) fsum = fsum + {8'd0, rgb};
            drive_sample(de, hs, vs, rgb, d);
            if (ln == 0 && c == vs_off) begin
               if (armed && have_pend) begin
                  if (pend.err == 4'd0) good_cnt = (good_cnt < LOCK) ? good_cnt + 1 : good_cnt;
                  else                  good_cnt = 0;
                  pend.lck = (good_cnt >= LOCK);
                  pend.cyc = drv_cyc + 1 + d;
                  exp_q.push_back(pend);
               end
               armed     = 1'b1;
               have_pend = 1'b0;
            end
         end
      end
      pend.h    = (short_ln == nact - 1) ? H_ACTIVE - 1 : H_ACTIVE;
      pend.v    = nact;
      pend.ht   = H_TOTAL;
      pend.sum  = fsum;
      pend.err  = {sync_ln >= 0, long_ln >= 0, nact != V_ACTIVE, short_ln >= 0};
      pend.lck  = 1'b0;
      pend.cyc  = 0;
      have_pend = 1'b1;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int na, sl, ll, sy, vo, dd;
      rst = 1'b1; pix_ce = 1'b0; lcd_de = 1'b0;
      lcd_hsync = ~HS_POL; lcd_vsync = ~VS_POL; lcd_rgb = 24'd0;
      repeat (3) @(negedge ref_clk);
      check_zero_outputs("reset");
      rst = 1'b0;

      repeat (3) drive_frame(6, -1, -1, -1, 0, 1, -1);
      drive_frame(6, int'($urandom_range(0, 5)), -1, -1, 0, 1, -1);
      repeat (2) drive_frame(6, -1, -1, -1, 0, 1, -1);
      drive_frame(5, -1, -1, -1, 0, 1, -1);
      drive_frame(6, -1, int'($urandom_range(0, 5)), -1, 0, 1, -1);
      drive_frame(6, -1, -1, int'($urandom_range(0, 5)), 0, 1, -1);
      repeat (3) drive_frame(6, -1, -1, -1, 0, 4, -1);

      for (int i = 0; i < 8; i++) begin
         na = ($urandom_range(0, 2) == 0) ? int'($urandom_range(5, 7)) : 6;
         sl = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, na - 1)) : -1;
         ll = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, na - 1)) : -1;
         sy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, na - 1)) : -1;
         vo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 20));
         dd = int'($urandom_range(1, 3));
         drive_frame(na, sl, ll, sy, vo, dd, -1);
      end

      drive_frame(6, -1, -1, -1, 0, 1, 2);
      repeat (3) drive_frame(6, -1, -1, -1, 0, 1, -1);
      drive_frame(6, -1, -1, -1, 7, 1, -1);

      repeat (10) @(negedge ref_clk);
      check_val("pending_results", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
